// File: rtl/mipi_rffe_slave_if.sv
// mipi_rffe_slave_if: RFFE pad pins plus the write-commit/status strobes of the slave.
interface mipi_rffe_slave_if;
    logic       sclk;
    logic       sdata_i;
    logic       sdata_o;
    logic       sdata_oe;
    logic       wr_vd;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       parity_err;
    logic       busy;
    modport master (output sclk, sdata_i,
                    input  sdata_o, sdata_oe, wr_vd, wr_addr, wr_data, parity_err, busy);
    modport slave  (input  sclk, sdata_i,
                    output sdata_o, sdata_oe, wr_vd, wr_addr, wr_data, parity_err, busy);
endinterface

// File: rtl/mipi_rffe_slave.sv
// mipi_rffe_slave: oversampled RFFE slave decoding Reg Write, Reg Read and Reg-0 Write into a 32x8 register file.
module mipi_rffe_slave #(
    parameter logic [3:0] USID_RST    = 4'hA,
    parameter int         SYNC_STAGES = 2,
    parameter int         REG_NBIT    = 8
) (
    input logic              clk,
    input logic              rst_n,
    mipi_rffe_slave_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RPARK, S_RDATA, S_EPARK, S_PARK, S_WAIT} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_s, r_sda_s;
    logic                   r_sclk_d, r_sda_d, r_arm;
    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [12:0]            r_sr;
    logic [4:0]             r_addr, r_wr_addr;
    logic [3:0]             r_usid;
    logic [REG_NBIT-1:0]    r_regs [32];
    logic [REG_NBIT-1:0]    r_wr_data;
    logic                   r_sdo, r_oe, r_wr_vd, r_perr;

    logic        w_sclk, w_sda, w_rise, w_fall, w_ssc, w_wr, w_sa_ok;
    logic [12:0] w_cmd;
    logic [7:0]  w_op;
    logic [3:0]  w_sa;

    assign w_sclk  = r_sclk_s[SYNC_STAGES-1];
    assign w_sda   = r_sda_s[SYNC_STAGES-1];
    assign w_rise  = w_sclk & ~r_sclk_d;
    assign w_fall  = ~w_sclk & r_sclk_d;
    assign w_ssc   = ~w_sclk & r_arm & ~w_sda & r_sda_d;
    // Shift register with the incoming bit appended; doubles as the 9-bit data+parity word in WDATA
    assign w_cmd   = {r_sr[11:0], w_sda};
    assign w_sa    = w_cmd[12:9];
    assign w_op    = w_cmd[8:1];
    assign w_wr    = w_op[7] | (w_op[7:5] == 3'b010);
    assign w_sa_ok = (w_sa == r_usid) | ((w_sa == 4'h0) & w_wr);

    assign bus.sdata_o    = r_sdo;
    assign bus.sdata_oe   = r_oe;
    assign bus.wr_vd      = r_wr_vd;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.parity_err = r_perr;
    assign bus.busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s <= '0;
            r_sda_s  <= '0;
            r_sclk_d <= 1'b0;
            r_sda_d  <= 1'b0;
            r_arm    <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], bus.sclk};
            r_sda_s  <= {r_sda_s[SYNC_STAGES-2:0], bus.sdata_i};
            r_sclk_d <= w_sclk;
            r_sda_d  <= w_sda;
            // Armed by an SDATA rise during SCLK low; the following fall is the SSC
            r_arm    <= ~w_sclk & (r_arm | (w_sda & ~r_sda_d)) & ~w_ssc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_addr    <= '0;
            r_usid    <= USID_RST;
            r_sdo     <= 1'b0;
            r_oe      <= 1'b0;
            r_wr_vd   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_perr    <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_wr_vd <= 1'b0;
            r_perr  <= 1'b0;
            if (w_ssc) begin
                r_state <= S_CMD;
                r_cnt   <= '0;
                r_oe    <= 1'b0;
                r_sdo   <= 1'b0;
            end else begin
                case (r_state)
                    S_CMD: if (w_fall) begin
                        r_sr  <= w_cmd;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd12) begin
                            r_cnt  <= '0;
                            r_addr <= w_op[4:0];
                            if (!(^w_cmd)) begin
                                r_perr  <= 1'b1;
                                r_state <= S_WAIT;
                            end else if (!w_sa_ok) r_state <= S_WAIT;
                            else if (w_op[7]) begin
                                r_regs[0] <= {1'b0, w_op[6:0]};
                                r_wr_vd   <= 1'b1;
                                r_wr_addr <= '0;
                                r_wr_data <= {1'b0, w_op[6:0]};
                                r_state   <= S_PARK;
                            end else if (w_op[7:5] == 3'b010) r_state <= S_WDATA;
                            else if (w_op[7:5] == 3'b011) r_state <= S_RPARK;
                            else r_state <= S_WAIT;
                        end
                    end
                    S_WDATA: if (w_fall) begin
                        r_sr  <= w_cmd;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd8) begin
                            r_cnt   <= '0;
                            r_state <= S_PARK;
                            if (^w_cmd[8:0]) begin
                                r_regs[r_addr] <= w_cmd[8:1];
                                r_wr_vd        <= 1'b1;
                                r_wr_addr      <= r_addr;
                                r_wr_data      <= w_cmd[8:1];
                                if (r_addr == 5'h1F) r_usid <= w_cmd[4:1];
                            end else r_perr <= 1'b1;
                        end
                    end
                    S_RPARK: if (w_fall) begin
                        r_sr[8:0] <= {r_regs[r_addr], ~^r_regs[r_addr]};
                        r_cnt     <= '0;
                        r_state   <= S_RDATA;
                    end
                    S_RDATA: if (w_rise) begin
                        r_oe  <= 1'b1;
                        r_sdo <= r_sr[8];
                        r_sr  <= {r_sr[11:0], 1'b0};
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd8) begin
                            r_cnt   <= '0;
                            r_state <= S_EPARK;
                        end
                    end
                    S_EPARK: if (w_rise) begin
                        r_sdo <= 1'b0;
                        r_cnt <= 4'd1;
                    end else if (w_fall && r_cnt == 4'd1) begin
                        r_oe    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                    S_PARK: if (w_fall) r_state <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule
